// File: rtl/tinyalu_pkg.sv
// Shared TinyALU opcode encoding and the golden-value helpers used by the scoreboard.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;

  // Widest operand the expected-value helper supports; callers cast down to their width.
  localparam int unsigned MaxDataW = 32;

  function automatic logic is_legal_op(input logic [2:0] op);
    return !((op == 3'b101) || (op == 3'b110));
  endfunction

  function automatic logic is_data_op(input logic [2:0] op);
    return (op == add_op) || (op == and_op) || (op == xor_op) || (op == mul_op);
  endfunction

  // Operands are zero-extended; the result is masked to 2*width bits.
  function automatic logic [2*MaxDataW-1:0] calc_expected(input logic [2:0]          op,
                                                          input logic [MaxDataW-1:0] a,
                                                          input logic [MaxDataW-1:0] b,
                                                          input int unsigned         width);
    logic [2*MaxDataW-1:0] a_ext, b_ext, res, mask;
    a_ext = {{MaxDataW{1'b0}}, a};
    b_ext = {{MaxDataW{1'b0}}, b};
    case (op)
      add_op:  res = a_ext + b_ext;
      and_op:  res = a_ext & b_ext;
      xor_op:  res = a_ext ^ b_ext;
      mul_op:  res = a_ext * b_ext;
      default: res = '0;
    endcase
    mask = '0;
    for (int i = 0; i < 2 * MaxDataW; i++) begin
      mask[i] = (i < 2 * width);
    end
    return res & mask;
  endfunction

endpackage

// File: rtl/alu_exp_fifo.sv
// Expected-result FIFO: power-of-two depth, flush beats push/pop, head visible the cycle after push.
module alu_exp_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally since Depth is a power of two.
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/alu_scoreboard_rtl.sv
// TinyALU scoreboard: predicts each operation's result, queues it, and checks DUT results in order.
module alu_scoreboard_rtl
  import tinyalu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [2:0]                op,
  input  logic [DATA_W-1:0]         A,
  input  logic [DATA_W-1:0]         B,
  input  logic                      res_valid,
  input  logic [2*DATA_W-1:0]       result,
  output logic [$clog2(DEPTH):0]    pending,
  output logic                      mismatch,
  output logic [2*DATA_W-1:0]       exp_value,
  output logic [2*DATA_W-1:0]       act_value,
  output logic [CNT_W-1:0]          pass_count,
  output logic [CNT_W-1:0]          fail_count,
  output logic [CNT_W-1:0]          unexpected_count,
  output logic [CNT_W-1:0]          illegal_count,
  output logic                      error
);

  localparam int unsigned ResW = 2 * DATA_W;

  logic            accept, do_push, do_pop, do_flush, is_illegal, is_unexp, is_fail;
  logic            fifo_full, fifo_empty;
  logic [ResW-1:0] head, exp_word;

  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, unexp_q, unexp_d, illegal_q, illegal_d;
  logic [ResW-1:0]  exp_q, exp_d, act_q, act_d;
  logic             mismatch_q, mismatch_d, error_q, error_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign exp_word = ResW'(calc_expected(op, MaxDataW'(A), MaxDataW'(B), DATA_W));

  assign accept     = op_valid & op_ready;
  assign do_push    = accept & is_data_op(op);
  assign do_flush   = accept & (op == rst_op);
  assign is_illegal = accept & ~is_legal_op(op);
  // Compare always sees the pre-edge head, so a same-cycle push never bypasses.
  assign do_pop     = res_valid & ~fifo_empty;
  assign is_unexp   = res_valid & fifo_empty;
  assign is_fail    = do_pop & (head != result);

  alu_exp_fifo #(
    .Width (ResW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (do_push),
    .pop_i   (do_pop),
    .flush_i (do_flush),
    .wdata_i (exp_word),
    .rdata_o (head),
    .count_o (pending),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    pass_d     = pass_q;
    fail_d     = fail_q;
    unexp_d    = unexp_q;
    illegal_d  = illegal_q;
    exp_d      = exp_q;
    act_d      = act_q;
    mismatch_d = is_fail;
    error_d    = error_q | is_fail | is_unexp | is_illegal;
    if (do_pop && !is_fail) pass_d = sat_inc(pass_q);
    if (is_fail) begin
      fail_d = sat_inc(fail_q);
      exp_d  = head;
      act_d  = result;
    end
    if (is_unexp)   unexp_d   = sat_inc(unexp_q);
    if (is_illegal) illegal_d = sat_inc(illegal_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_q     <= '0;
      fail_q     <= '0;
      unexp_q    <= '0;
      illegal_q  <= '0;
      exp_q      <= '0;
      act_q      <= '0;
      mismatch_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      unexp_q    <= unexp_d;
      illegal_q  <= illegal_d;
      exp_q      <= exp_d;
      act_q      <= act_d;
      mismatch_q <= mismatch_d;
      error_q    <= error_d;
    end
  end

  assign op_ready         = ~fifo_full;
  assign mismatch         = mismatch_q;
  assign exp_value        = exp_q;
  assign act_value        = act_q;
  assign pass_count       = pass_q;
  assign fail_count       = fail_q;
  assign unexpected_count = unexp_q;
  assign illegal_count    = illegal_q;
  assign error            = error_q;

endmodule
